// File: rtl/spart_echo_ctrl.sv
// Echo controller for a SPART: programs the baud divisor, then copies every received
// byte through a circular buffer back out to the transmitter (optionally case-swapped).
module spart_echo_ctrl #(
  parameter int CLK_HZ     = 25000000,
  parameter int FIFO_DEPTH = 8,
  parameter bit CASE_SWAP  = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  br_cfg,
  input  logic                        rda,
  input  logic                        tbr,
  output logic                        iocs,
  output logic                        iorw,
  output logic [1:0]                  ioaddr,
  inout  wire  [7:0]                  databus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic [15:0]                 rx_count,
  output logic [15:0]                 tx_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / (16 * 4800));
  localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / (16 * 9600));
  localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / (16 * 19200));
  localparam logic [15:0] DIV_38400 = 16'(CLK_HZ / (16 * 38400));

  typedef enum logic [2:0] {
    CFG_LO, CFG_HI, IDLE, RD_DATA, WR_DATA, WAIT_TBR
  } state_t;

  state_t         state, state_next;
  logic [1:0]     br_applied;
  logic [1:0]     cfg_pending;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           full, empty, push, pop;
  logic           drive_en;
  logic [7:0]     drive_data, head, tx_byte;
  logic [15:0]    div_lo_sel, div_hi_sel;

  function automatic logic [15:0] div_for(input logic [1:0] sel);
    case (sel)
      2'b00:   return DIV_4800;
      2'b01:   return DIV_9600;
      2'b10:   return DIV_19200;
      default: return DIV_38400;
    endcase
  endfunction

  function automatic logic [7:0] swap_case(input logic [7:0] b);
    if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))
      return b ^ 8'h20;
    return b;
  endfunction

  // Both divisor halves come from the setting captured in CFG_LO, so a br_cfg change
  // between the two writes cannot mix halves; IDLE then sees the mismatch and redoes it.
  assign div_lo_sel = div_for(br_cfg);
  assign div_hi_sel = div_for(cfg_pending);

  assign head    = mem[rd_ptr];
  assign tx_byte = CASE_SWAP ? swap_case(head) : head;
  assign full    = (fifo_count == FULL_COUNT);
  assign empty   = (fifo_count == '0);
  assign push    = (state == RD_DATA) && !full;
  assign pop     = (state == WR_DATA);
  assign databus = drive_en ? drive_data : 8'hzz;

  always_ff @(posedge clk) begin
    if (rst) state <= CFG_LO;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    iocs       = 1'b0;
    iorw       = 1'b1;
    ioaddr     = 2'b01;
    drive_en   = 1'b0;
    drive_data = 8'h00;
    case (state)
      CFG_LO: begin
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b10;
        drive_en = 1'b1; drive_data = div_lo_sel[7:0];
        state_next = CFG_HI;
      end
      CFG_HI: begin
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b11;
        drive_en = 1'b1; drive_data = div_hi_sel[15:8];
        state_next = IDLE;
      end
      IDLE: begin
        if (br_cfg != br_applied) state_next = CFG_LO;
        else if (rda)             state_next = RD_DATA;
        else if (!empty && tbr)   state_next = WR_DATA;
      end
      RD_DATA: begin
        iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b00;
        state_next = IDLE;
      end
      WR_DATA: begin
        iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b00;
        drive_en = 1'b1; drive_data = tx_byte;
        state_next = WAIT_TBR;
      end
      WAIT_TBR: begin
        if (tbr) state_next = IDLE;
      end
      default: state_next = CFG_LO;
    endcase
    // Holding reset releases the bus at once, abandoning any in-flight write.
    if (rst) begin
      iocs     = 1'b0;
      iorw     = 1'b1;
      ioaddr   = 2'b01;
      drive_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      overflow    <= 1'b0;
      rx_count    <= '0;
      tx_count    <= '0;
      br_applied  <= 2'b00;
      cfg_pending <= 2'b00;
    end else begin
      if (state == CFG_LO) cfg_pending <= br_cfg;
      if (state == CFG_HI) br_applied  <= cfg_pending;
      if (state == RD_DATA && full) overflow <= 1'b1;
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        rx_count <= rx_count + 16'd1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        tx_count <= tx_count + 16'd1;
      end
      if (push)     fifo_count <= fifo_count + 1'b1;
      else if (pop) fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= databus;
  end

endmodule

// File: doc/spart_echo_ctrl.md
SPART_ECHO_CTRL -- requirements
Module: spart_echo_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 25000000, system clock frequency in Hz used to derive baud divisors.
REQ-002 Parameter FIFO_DEPTH, default 8, echo buffer entries; power of two, 2..64.
REQ-003 Parameter CASE_SWAP, default 0; 0 = echo bytes unchanged, 1 = swap ASCII case of a-z/A-Z on transmit.
REQ-004 clk  input  1  system clock; every register updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
REQ-007 rda  input  1  SPART receive data available.
REQ-008 tbr  input  1  SPART transmit buffer ready.
REQ-009 iocs  output  1  SPART chip select.
REQ-010 iorw  output  1  1=read, 0=write.
REQ-011 ioaddr  output  2  00=rx/tx buffer, 01=status, 10=divisor low, 11=divisor high.
REQ-012 databus  inout  8  bidirectional bus; driven only during write cycles, else high-Z.
REQ-013 fifo_count  output  $clog2(FIFO_DEPTH)+1  current echo-buffer occupancy.
REQ-014 overflow  output  1  sticky: a received byte was dropped because the buffer was full.
REQ-015 rx_count, tx_count  output  16 each  bytes accepted into / written out of the buffer, wrap 0xFFFF->0x0000.

Function
REQ-016 Divisor SHALL be CLK_HZ/(16*baud), truncated, 16 bits; at 25 MHz: 325, 162, 81, 40.
REQ-017 FSM states SHALL be CFG_LO, CFG_HI, IDLE, RD_DATA, WR_DATA, WAIT_TBR.
REQ-018 Default outputs in every state not listed: iocs=0, iorw=1, ioaddr=01, databus high-Z.
REQ-019 CFG_LO: iocs=1, iorw=0, ioaddr=10, drive divisor[7:0]; next CFG_HI.
REQ-020 CFG_HI: iocs=1, iorw=0, ioaddr=11, drive divisor[15:8]; next IDLE; register br_cfg as the applied setting.
REQ-021 IDLE priority, highest first: br_cfg differs from the applied setting -> CFG_LO; rda=1 -> RD_DATA; buffer non-empty and tbr=1 -> WR_DATA; else stay IDLE.
REQ-022 RD_DATA: iocs=1, iorw=1, ioaddr=00; databus sampled at the closing edge; push if not full, else drop and set overflow; next IDLE.
REQ-023 WR_DATA: iocs=1, iorw=0, ioaddr=00, drive buffer head (case-swapped when CASE_SWAP=1); pop at the closing edge; tx_count+1; next WAIT_TBR.
REQ-024 WAIT_TBR: bus idle per REQ-018; stay at least one cycle; leave to IDLE on the first cycle after entry with tbr=1.
REQ-025 Buffer SHALL be FIFO order, circular pointers wrapping at FIFO_DEPTH; fifo_count range 0..FIFO_DEPTH.
REQ-026 rx_count SHALL increment only on a successful push; dropped bytes SHALL NOT count.
REQ-027 Push and pop never occur in the same cycle; occupancy SHALL change by at most 1 per cycle.
REQ-028 A br_cfg change during RD_DATA/WR_DATA/WAIT_TBR SHALL be acted on at the next IDLE; buffered data SHALL be retained.
REQ-029 Case swap SHALL affect only 0x41-0x5A and 0x61-0x7A (XOR 0x20); all other bytes pass unchanged.
REQ-030 databus SHALL never be driven in RD_DATA or in any cycle with iorw=1.

Reset
REQ-031 rst=1 at a clock edge: state=CFG_LO, buffer empty, fifo_count=0, overflow=0, rx_count=0, tx_count=0, applied br_cfg cleared.
REQ-032 First cycles after reset deassertion SHALL program the divisor (CFG_LO, CFG_HI) before any data transfer.
REQ-033 Reset mid-transfer SHALL abort the transfer; the in-flight byte is discarded and the bus released in the same cycle the state becomes CFG_LO.

Verification
REQ-034 Reset release, br_cfg=01, CLK_HZ=25e6 -> cycle 1 writes 0xA2 at ioaddr 10, cycle 2 writes 0x00 at ioaddr 11, then IDLE.
REQ-035 rda pulse with bus=0x41, tbr=1 -> RD_DATA, then WR_DATA drives 0x41 (0x61 with CASE_SWAP=1); rx_count=tx_count=1.
REQ-036 tbr=0, FIFO_DEPTH=8, 9 rda bytes 0x00..0x08 -> fifo_count=8, overflow=1, rx_count=8; tbr=1 -> transmits 0x00..0x07 in order.
REQ-037 br_cfg 01->11 while in WAIT_TBR -> after IDLE, divisor 0x0028/0x0000 written before the next data transfer.
REQ-038 rda=1 and non-empty buffer with tbr=1 simultaneously in IDLE -> RD_DATA first, WR_DATA on the following IDLE pass.
REQ-039 rst=1 during WR_DATA -> databus high-Z and all counters/overflow zero on the next cycle, CFG_LO entered.
